// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
// Walks the operands SLICE bits per clock from the MSB down and produces a
// one-hot less/equal/greater result. Signed operands are converted to
// offset binary at capture, so a single unsigned slice compare serves both
// modes. The result is held until the edge that enters DONE on the next
// operation.
module seq_magnitude_comparator #(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             signedMode,
  input  logic [WIDTH-1:0] inputP,
  input  logic [WIDTH-1:0] inputQ,
  output logic             busy,
  output logic             done,
  output logic             pLessThanQ,
  output logic             pEqualToQ,
  output logic             pGreaterThanQ
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  // Inverting the sign bit maps two's complement onto offset binary.
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  pReg;
  logic [WIDTH-1:0]  qReg;
  logic [IDXW-1:0]   index;
  logic              decided;
  logic              decLt;
  logic              decGt;

  logic [SLICE-1:0]  pSlices [N];
  logic [SLICE-1:0]  qSlices [N];
  logic [SLICE-1:0]  pCur;
  logic [SLICE-1:0]  qCur;
  logic              sliceLt;
  logic              sliceGt;
  logic              finalLt;
  logic              finalGt;
  logic              finishNow;
  logic              resLt;
  logic              resGt;

  // Split the captured operands into slices so the walk is a plain array select.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : gSlice
      assign pSlices[gi] = pReg[gi*SLICE +: SLICE];
      assign qSlices[gi] = qReg[gi*SLICE +: SLICE];
    end
  endgenerate

  // Compare the current slice and decide whether this edge finishes the operation.
  always_comb begin
    pCur    = pSlices[index];
    qCur    = qSlices[index];
    sliceLt = (pCur < qCur);
    sliceGt = (pCur > qCur);
    // The first (most significant) difference wins over later slices.
    finalLt = decided ? decLt : sliceLt;
    finalGt = decided ? decGt : sliceGt;
    if (EARLY_EXIT != 0) begin
      finishNow = sliceLt | sliceGt | (index == '0);
      resLt     = sliceLt;
      resGt     = sliceGt;
    end else begin
      finishNow = (index == '0);
      resLt     = finalLt;
      resGt     = finalGt;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      pReg          <= '0;
      qReg          <= '0;
      index         <= '0;
      decided       <= 1'b0;
      decLt         <= 1'b0;
      decGt         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pLessThanQ    <= 1'b0;
      pEqualToQ     <= 1'b0;
      pGreaterThanQ <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pReg    <= signedMode ? (inputP ^ SIGN_FLIP) : inputP;
            qReg    <= signedMode ? (inputQ ^ SIGN_FLIP) : inputQ;
            index   <= IDXW'(N - 1);
            decided <= 1'b0;
            decLt   <= 1'b0;
            decGt   <= 1'b0;
            busy    <= 1'b1;
            state   <= COMPARE;
          end else begin
            state   <= IDLE;
          end
        end
        COMPARE: begin
          if (finishNow) begin
            pLessThanQ    <= resLt;
            pGreaterThanQ <= resGt;
            pEqualToQ     <= ~(resLt | resGt);
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            index   <= index - 1'b1;
            decided <= decided | sliceLt | sliceGt;
            decLt   <= finalLt;
            decGt   <= finalGt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Scoreboard bench for seq_magnitude_comparator: an early-exit instance and a
// fixed-latency instance share operand inputs but have separate start lines.
module tb_seq_magnitude_comparator;

  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;

  logic         clk = 1'b0;
  logic         rstN;
  logic [1:0]   start;
  logic         signedMode;
  logic [W-1:0] inputP;
  logic [W-1:0] inputQ;
  logic [1:0]   busy;
  logic [1:0]   done;
  logic [1:0]   ltO;
  logic [1:0]   eqO;
  logic [1:0]   gtO;

  seq_magnitude_comparator #(.WIDTH(W), .SLICE(S), .EARLY_EXIT(1)) dutEarly (
    .clk(clk), .rstN(rstN), .start(start[0]), .signedMode(signedMode),
    .inputP(inputP), .inputQ(inputQ), .busy(busy[0]), .done(done[0]),
    .pLessThanQ(ltO[0]), .pEqualToQ(eqO[0]), .pGreaterThanQ(gtO[0])
  );

  seq_magnitude_comparator #(.WIDTH(W), .SLICE(S), .EARLY_EXIT(0)) dutFull (
    .clk(clk), .rstN(rstN), .start(start[1]), .signedMode(signedMode),
    .inputP(inputP), .inputQ(inputQ), .busy(busy[1]), .done(done[1]),
    .pLessThanQ(ltO[1]), .pEqualToQ(eqO[1]), .pGreaterThanQ(gtO[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic [2:0]   res;      // {lt, eq, gt}
    int           startCyc; // edge that samples start
    int           doneCyc;  // edge that enters DONE
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [2:0] held [2];
  int         nChecks = 0;
  int         nPass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic failEvent(input string name, input string what);
    nChecks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference: plain integer comparison; the deciding slice is the one that
  // holds the highest differing bit.
  function automatic exp_t model(input logic [W-1:0] p, input logic [W-1:0] q,
                                 input logic sm, input bit early, input int k);
    exp_t e;
    logic lt, gt;
    int   j;
    bit   found;
    if (sm) begin
      lt = ($signed(p) < $signed(q));
      gt = ($signed(p) > $signed(q));
    end else begin
      lt = (p < q);
      gt = (p > q);
    end
    j = N;
    found = 0;
    if (early && p != q) begin
      for (int b = W - 1; b >= 0; b--) begin
        if (!found && p[b] != q[b]) begin
          j = N - b / S;
          found = 1;
        end
      end
    end
    e.p = p;
    e.q = q;
    e.res = {lt, ~(lt | gt), gt};
    e.startCyc = k;
    e.doneCyc = k + j;
    return e;
  endfunction

  // Monitor: checks busy, done timing, result and result hold every cycle.
  task automatic monitorOne(input int i);
    exp_t h;
    bit   have;
    logic busyExp;
    logic [2:0] got;
    h = '{default: '0};
    if (i == 0) begin
      have = (q0.size() != 0);
      if (have) h = q0[0];
    end else begin
      have = (q1.size() != 0);
      if (have) h = q1[0];
    end
    got = {ltO[i], eqO[i], gtO[i]};
    busyExp = have && (cyc >= h.startCyc) && (cyc < h.doneCyc);
    check($sformatf("busy dut%0d cyc%0d", i, cyc), 32'(busy[i]), 32'(busyExp));
    if (done[i]) begin
      if (!have) begin
        failEvent($sformatf("unexpectedDone dut%0d", i), "done=1 required done=0");
      end else begin
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        check($sformatf("doneCycle dut%0d", i), 32'(cyc), 32'(h.doneCyc));
        check($sformatf("result dut%0d P=%h Q=%h", i, h.p, h.q), 32'(got), 32'(h.res));
        held[i] = h.res;
        $display("cyc=%0d dut%0d P=%h Q=%h ltEqGt=%b expected=%b", cyc, i, h.p, h.q, got, h.res);
      end
    end else begin
      check($sformatf("hold dut%0d cyc%0d", i, cyc), 32'(got), 32'(held[i]));
      if (have && cyc >= h.doneCyc) begin
        failEvent($sformatf("missedDone dut%0d", i), "done=0 required done=1");
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    monitorOne(0);
    monitorOne(1);
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  // Raise start with new operands and enqueue the expected response.
  task automatic issue(input int i, input logic [W-1:0] p, input logic [W-1:0] q, input logic sm);
    exp_t e;
    inputP = p;
    inputQ = q;
    signedMode = sm;
    start[i] = 1'b1;
    e = model(p, q, sm, (i == 0), cyc + 1);
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic waitDone(input int i);
    bit seen;
    seen = 0;
    for (int n = 0; n < 4 * N + 8 && !seen; n++) begin
      stepCycle();
      if (done[i]) seen = 1;
    end
    if (!seen) failEvent($sformatf("doneTimeout dut%0d", i), "no done within budget");
  endtask

  task automatic runOp(input int i, input logic [W-1:0] p, input logic [W-1:0] q, input logic sm);
    issue(i, p, q, sm);
    stepCycle();
    start[i] = 1'b0;
    waitDone(i);
  endtask

  task automatic randomOps(input int i, input int count);
    logic [W-1:0] p, q;
    int r;
    for (int n = 0; n < count; n++) begin
      p = W'($urandom);
      r = $urandom_range(0, 3);
      if (r == 0) q = p;
      else if (r == 1) q = p ^ (W'(1) << $urandom_range(0, W - 1));
      else q = W'($urandom);
      runOp(i, p, q, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) stepCycle();
    end
  endtask

  initial begin
    rstN = 1'b0;
    start = 2'b00;
    signedMode = 1'b0;
    inputP = '0;
    inputQ = '0;
    held[0] = 3'b000;
    held[1] = 3'b000;
    repeat (3) stepCycle();
    check("resetBusy", 32'(busy), 32'(0));
    check("resetDone", 32'(done), 32'(0));
    check("resetResults", 32'({ltO, eqO, gtO}), 32'(0));
    rstN = 1'b1;
    stepCycle();

    // Early-exit instance: directed cases
    runOp(0, 16'h1234, 16'h1235, 1'b0);
    runOp(0, 16'hA000, 16'h1000, 1'b0);
    runOp(0, 16'hA000, 16'h1000, 1'b1);
    runOp(0, 16'hFFFF, 16'hFFFF, 1'b0);
    runOp(0, 16'hFFFF, 16'hFFFF, 1'b1);
    runOp(0, 16'h8000, 16'h7FFF, 1'b1);
    stepCycle();

    // Handshake: start during COMPARE ignored, then start held through DONE
    issue(0, 16'h1234, 16'h1235, 1'b0);
    stepCycle();
    start[0] = 1'b0;
    stepCycle();
    inputP = 16'hFFFF;
    inputQ = 16'h0000;
    signedMode = 1'b1;
    start[0] = 1'b1;
    stepCycle();
    start[0] = 1'b0;
    waitDone(0);
    check("firstResultKept", 32'({ltO[0], eqO[0], gtO[0]}), 32'(3'b100));
    issue(0, 16'h0001, 16'h0002, 1'b0);
    stepCycle();
    check("holdDuringBusy", 32'({ltO[0], eqO[0], gtO[0]}), 32'(3'b100));
    check("busyAfterRecapture", 32'(busy[0]), 32'(1));
    waitDone(0);
    issue(0, 16'h0005, 16'h0005, 1'b0);
    stepCycle();
    start[0] = 1'b0;
    waitDone(0);
    stepCycle();

    randomOps(0, 150);

    // Fixed-latency instance
    runOp(1, 16'h8000, 16'h0000, 1'b0);
    runOp(1, 16'h0001, 16'h0000, 1'b0);
    runOp(1, 16'h8000, 16'h7FFF, 1'b1);
    runOp(1, 16'hFFFF, 16'hFFFF, 1'b1);
    randomOps(1, 100);
    stepCycle();

    // Asynchronous reset in the middle of COMPARE
    issue(0, 16'h1234, 16'h1235, 1'b0);
    stepCycle();
    start[0] = 1'b0;
    stepCycle();
    @(posedge clk);
    #2;
    rstN = 1'b0;
    q0.delete();
    q1.delete();
    held[0] = 3'b000;
    held[1] = 3'b000;
    #1;
    check("abortBusy", 32'(busy[0]), 32'(0));
    check("abortDone", 32'(done[0]), 32'(0));
    check("abortResults", 32'({ltO[0], eqO[0], gtO[0]}), 32'(0));
    repeat (3) stepCycle();
    #2;
    rstN = 1'b1;
    repeat (6) stepCycle();
    runOp(0, 16'h00F0, 16'h000F, 1'b0);
    runOp(1, 16'h00F0, 16'h000F, 1'b1);
    repeat (2) stepCycle();

    check("queue0Drained", 32'(q0.size()), 32'(0));
    check("queue1Drained", 32'(q1.size()), 32'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
